// File: rtl/note_period_gen.sv
// rtl/note_period_gen.sv - multi-channel note-to-period generator
// Octave/semitone from iterative divide-by-12, period = rounded base >> octave.
module note_period_gen #(
  parameter int NCH       = 4,
  parameter int NBIT_CH   = 2,
  parameter int NBIT_NOTE = 7,
  parameter int NBIT_OUT  = 16,
  parameter int NOTE_MIN  = 12,
  parameter int NOTE_MAX  = 119,
  parameter int RST_VAL   = 916
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NBIT_CH-1:0]      req_ch,
  input  logic [NBIT_NOTE-1:0]    req_note,
  output logic                    resp_valid,
  output logic [NBIT_CH-1:0]      resp_ch,
  output logic                    resp_err,
  output logic [NBIT_OUT-1:0]     resp_period,
  output logic [NCH*NBIT_OUT-1:0] period_all
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int NBIT_OCT = $clog2((1 << NBIT_NOTE) / 12 + 1);
  localparam int NW       = NBIT_OUT + 1;
  localparam int NCH_CODE = 1 << NBIT_CH;

  localparam logic [NBIT_NOTE-1:0] NMIN   = NBIT_NOTE'(NOTE_MIN);
  localparam logic [NBIT_NOTE-1:0] NMAX   = NBIT_NOTE'(NOTE_MAX);
  localparam logic [NBIT_NOTE-1:0] TWELVE = NBIT_NOTE'(12);

  // One bit per channel code; lets the range check work when NCH < 2**NBIT_CH.
  function automatic logic [NCH_CODE-1:0] ch_mask_f();
    logic [NCH_CODE-1:0] m;
    m = '0;
    for (int i = 0; i < NCH_CODE; i++) m[i] = (i < NCH);
    return m;
  endfunction

  localparam logic [NCH_CODE-1:0] CH_MASK = ch_mask_f();

  function automatic logic [NW-1:0] base_f(input logic [3:0] idx);
    case (idx)
      4'd0:    base_f = NW'(24660);
      4'd1:    base_f = NW'(23276);
      4'd2:    base_f = NW'(21969);
      4'd3:    base_f = NW'(20736);
      4'd4:    base_f = NW'(19572);
      4'd5:    base_f = NW'(18474);
      4'd6:    base_f = NW'(17437);
      4'd7:    base_f = NW'(16458);
      4'd8:    base_f = NW'(15535);
      4'd9:    base_f = NW'(14663);
      4'd10:   base_f = NW'(13840);
      4'd11:   base_f = NW'(13063);
      default: base_f = '0;
    endcase
  endfunction

  logic [1:0]           state;
  logic [NBIT_CH-1:0]   ch_r;
  logic [NBIT_NOTE-1:0] rem;
  logic [NBIT_OCT-1:0]  oct;
  logic [NW-1:0]        base_v;
  logic [NW-1:0]        rnd;
  logic [NBIT_OUT-1:0]  p;
  logic                 note_ok;
  logic                 ch_ok;

  assign req_ready = (state == S_IDLE) && en;
  assign note_ok   = (req_note >= NMIN) && (req_note <= NMAX);
  assign ch_ok     = CH_MASK[req_ch];

  // Half-LSB rounding term is zero at octave 0, so one formula covers both cases.
  always_comb begin
    base_v = base_f(rem[3:0]);
    rnd    = (NW'(1) << oct) >> 1;
    p      = NBIT_OUT'((base_v + rnd) >> oct);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      ch_r        <= '0;
      rem         <= '0;
      oct         <= '0;
      resp_valid  <= 1'b0;
      resp_ch     <= '0;
      resp_err    <= 1'b0;
      resp_period <= '0;
      period_all  <= {NCH{NBIT_OUT'(RST_VAL)}};
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            ch_r <= req_ch;
            if (note_ok && ch_ok) begin
              rem   <= req_note - NMIN;
              oct   <= '0;
              state <= S_DIV;
            end else begin
              resp_valid  <= 1'b1;
              resp_err    <= 1'b1;
              resp_ch     <= req_ch;
              resp_period <= '0;
              state       <= S_DONE;
            end
          end
        end
        S_DIV: begin
          if (rem >= TWELVE) begin
            rem <= rem - TWELVE;
            oct <= oct + NBIT_OCT'(1);
          end else begin
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          for (int c = 0; c < NCH; c++) begin
            if (ch_r == NBIT_CH'(c)) period_all[c*NBIT_OUT +: NBIT_OUT] <= p;
          end
          resp_valid  <= 1'b1;
          resp_err    <= 1'b0;
          resp_ch     <= ch_r;
          resp_period <= p;
          state       <= S_DONE;
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_period_gen.sv
// tb/tb_note_period_gen.sv - scoreboard bench for note_period_gen
// Driver pushes model results; negedge monitor pops on each consumed response.
module tb_note_period_gen;

  localparam int NCH = 3;
  localparam int NBIT_CH = 2;
  localparam int NBIT_OUT = 16;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    en;
  logic                    req_valid;
  logic                    req_ready;
  logic [NBIT_CH-1:0]      req_ch;
  logic [6:0]              req_note;
  logic                    resp_valid;
  logic [NBIT_CH-1:0]      resp_ch;
  logic                    resp_err;
  logic [NBIT_OUT-1:0]     resp_period;
  logic [NCH*NBIT_OUT-1:0] period_all;

  note_period_gen #(.NCH(NCH), .NBIT_CH(NBIT_CH)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_note(req_note),
    .resp_valid(resp_valid), .resp_ch(resp_ch), .resp_err(resp_err),
    .resp_period(resp_period), .period_all(period_all)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                      ch;
    int                      err;
    int                      per;
    int                      lat;
    logic [NCH*NBIT_OUT-1:0] snap;
  } item_t;

  item_t sb_q[$];
  int    acc_q[$];
  int    exp_per[NCH];
  int    base_tab[12] = '{24660, 23276, 21969, 20736, 19572, 18474,
                          17437, 16458, 15535, 14663, 13840, 13063};
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    resp_cnt = 0;
  int    pushed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endfunction

  function automatic logic [NCH*NBIT_OUT-1:0] snapshot();
    logic [NCH*NBIT_OUT-1:0] s;
    for (int c = 0; c < NCH; c++) s[c*NBIT_OUT +: NBIT_OUT] = NBIT_OUT'(exp_per[c]);
    return s;
  endfunction

  // Reference: octave and semitone straight from division, period by rounded shift.
  function automatic void push_item(input int ch, input int note, input int extra, output int base_lat);
    item_t it;
    int o, s, per;
    it.ch  = ch;
    it.err = (note < 12 || note > 119 || ch >= NCH) ? 1 : 0;
    if (it.err == 1) begin
      it.per   = 0;
      base_lat = 1;
    end else begin
      o   = (note - 12) / 12;
      s   = (note - 12) % 12;
      per = (o == 0) ? base_tab[s] : (base_tab[s] + (1 << (o - 1))) >> o;
      per = per & 16'hFFFF;
      exp_per[ch] = per;
      it.per   = per;
      base_lat = o + 3;
    end
    it.lat  = base_lat + extra;
    it.snap = snapshot();
    sb_q.push_back(it);
    pushed++;
  endfunction

  always @(negedge clk) begin
    if (rstn && resp_valid && en) begin
      item_t it;
      int a;
      resp_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got response ch=%0d, required none", resp_ch);
      end else begin
        it = sb_q.pop_front();
        a  = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
        chk("resp_ch", longint'(resp_ch), it.ch);
        chk("resp_err", longint'(resp_err), it.err);
        chk("resp_period", longint'(resp_period), it.per);
        chk("latency", cyc - a + 1, it.lat);
        chk("period_all", longint'(period_all), longint'(it.snap));
      end
    end
  end

  task automatic wait_accept(output int a);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        a = cyc;
        acc_q.push_back(cyc);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: req_ready never rose, required within 300 cycles");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "accept timeout");
  endtask

  // n>0 drops en for n cycles starting d cycles after the accept edge.
  task automatic send(input int ch, input int note, input int n, input int d);
    int lat, a, dd;
    push_item(ch, note, n, lat);
    req_valid = 1'b1;
    req_ch    = NBIT_CH'(ch);
    req_note  = 7'(note);
    wait_accept(a);
    req_valid = 1'b0;
    if (n > 0) begin
      dd = (d < 0) ? $urandom_range(0, lat - 1) : ((d > lat - 1) ? lat - 1 : d);
      repeat (dd) begin @(posedge clk); #1; end
      en = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
      en = 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && sb_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    int lat_a, lat_b, a1, a2, rc, ch, note, n;
    rstn = 1'b0; en = 1'b1; req_valid = 1'b0; req_ch = '0; req_note = '0;
    for (int c = 0; c < NCH; c++) exp_per[c] = 916;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) chk("rst_period", longint'(period_all[c*NBIT_OUT +: NBIT_OUT]), 916);
    chk("rst_resp_valid", longint'(resp_valid), 0);
    chk("rst_req_ready", longint'(req_ready), 1);
    @(posedge clk); #1;

    send(1, 12, 0, 0);
    send(0, 119, 0, 0);
    send(0, 60, 0, 0);
    send(0, 80, 0, 0);
    send(0, 69, 0, 0);
    send(2, 11, 0, 0);
    send(2, 120, 0, 0);
    send(NCH, 50, 0, 0);
    drain();

    // Held request: second capture only after DONE, exactly two responses.
    rc = resp_cnt;
    push_item(2, 119, 0, lat_a);
    push_item(2, 119, 0, lat_b);
    req_valid = 1'b1; req_ch = 2'd2; req_note = 7'd119;
    wait_accept(a1);
    @(negedge clk);
    chk("busy_ready", longint'(req_ready), 0);
    wait_accept(a2);
    req_valid = 1'b0;
    chk("hold_gap", a2 - a1, lat_a + 1);
    drain();
    chk("hold_resp_count", resp_cnt - rc, 2);

    send(1, 100, 5, 3);
    drain();

    // Reset during DIV aborts the request silently.
    req_valid = 1'b1; req_ch = 2'd2; req_note = 7'd100;
    wait_accept(a1);
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rc = resp_cnt;
    rstn = 1'b0;
    acc_q.delete();
    for (int c = 0; c < NCH; c++) exp_per[c] = 916;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b1;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) chk("midreset_period", longint'(period_all[c*NBIT_OUT +: NBIT_OUT]), 916);
    repeat (20) @(posedge clk);
    #1;
    chk("midreset_no_resp", resp_cnt - rc, 0);

    for (int i = 0; i < 60; i++) begin
      ch   = $urandom_range(0, 3);
      note = ($urandom % 4 == 0) ? $urandom_range(0, 127) : $urandom_range(12, 119);
      n    = ($urandom % 4 == 0) ? $urandom_range(1, 4) : 0;
      send(ch, note, n, -1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    chk("resp_total", resp_cnt, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_period_gen.md
Name: note_period_gen

Overview:
- Multi-channel note-to-period generator for the synth oscillators. It replaces the flat 128-entry tri/squ/sin period ROM.
- Stores only a 12-entry base-octave table. Each period is derived arithmetically: iterative divide-by-12 to get octave and semitone, then a rounded right shift by the octave.
- Requests arrive on a valid/ready handshake tagged with a channel number. Results are written to a per-channel period register bank that feeds NCH oscillator voices, and each request returns one response pulse.

Parameters:
- NCH, 4, number of voice channels (1..16)
- NBIT_CH, 2, width of channel index; must be ≥ clog2(NCH)
- NBIT_NOTE, 7, note number width
- NBIT_OUT, 16, period word width
- NOTE_MIN, 12, lowest legal note; maps to base table entry 0
- NOTE_MAX, 119, highest legal note
- RST_VAL, 916, reset value of every channel period (note 69)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- en  in  1  global enable; 0 freezes the FSM and all registers
- req_valid  in  1  request present
- req_ready  out  1  = (state==IDLE) & en; combinational
- req_ch  in  NBIT_CH  target channel
- req_note  in  NBIT_NOTE  note number
- resp_valid  out  1  response pulse, registered
- resp_ch  out  NBIT_CH  channel of the response
- resp_err  out  1  1 = request rejected (note or channel out of range)
- resp_period  out  NBIT_OUT  period written; 0 when resp_err=1
- period_all  out  NCH*NBIT_OUT  channel c occupies bits [c*NBIT_OUT +: NBIT_OUT]

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; every channel period=RST_VAL.
  - resp_valid=0, resp_err=0, resp_ch=0, resp_period=0; internal rem/oct=0.
  - Reset mid-operation aborts the request with no response.
- Base table (entries 0..11): 24660, 23276, 21969, 20736, 19572, 18474, 17437, 16458, 15535, 14663, 13840, 13063.
- Accept: on a clk edge with req_valid & req_ready, capture ch and note.
  - If note<NOTE_MIN, note>NOTE_MAX or ch≥NCH: next state DONE with err=1.
  - Otherwise: next state DIV with rem=note−NOTE_MIN, oct=0.
- DIV: each cycle, if rem≥12 then rem−=12 and oct+=1; else next state SHIFT. DIV therefore occupies oct_final+1 cycles.
- SHIFT (one cycle):
  - p = oct==0 ? base[rem] : (base[rem] + 2^(oct−1)) >> oct, i.e. round half up.
  - Compute in NBIT_OUT+1 bits, then truncate to NBIT_OUT.
  - Write p to period[ch]; go to DONE.
- DONE: resp_valid=1 for the cycle in which the state is DONE; resp_ch, resp_err and resp_period are stable alongside it. Next state is IDLE.
- Latency, counted in cycles after the accept edge:
  - Legal request: resp_valid is high in cycle oct+3; period_all updates on the edge entering DONE.
  - Illegal request: resp_valid and resp_err are high in cycle 1; no period register changes.
- Throughput: one request in flight. req_ready=0 outside IDLE; requests are not queued, so the source must hold req_valid.
- en=0:
  - All state, counters and registers hold; req_ready=0.
  - If the FSM is in DONE, resp_valid stays asserted until en returns and one enabled cycle passes.
- Channels not addressed keep their period indefinitely.
- A repeated request to the same channel overwrites it.

Test Plan:
- Reset, then read period_all → every channel = 916; resp_valid=0; req_ready=1 with en=1.
- req ch1 note 12 → resp_valid in cycle 3, resp_period=24660, resp_err=0; channel 1 = 24660; other channels stay 916.
- req ch0 note 119 → oct=8, rem=11; resp_valid in cycle 11; period 51. Then note 60 → 1541, note 80 → 485, note 69 → 916.
- req note 11, then note 120, then ch=NCH (when NCH<2^NBIT_CH) → each gives resp_valid in cycle 1 with resp_err=1 and resp_period=0; period_all unchanged.
- Hold req_valid during a busy period → req_ready=0 and no second capture; the second request is accepted on the cycle after DONE and yields exactly two responses.
- Drop en for 5 cycles during DIV of note 100 → latency is extended by exactly 5 cycles, result is 153. Assert rstn mid-DIV → no response and all channels return to 916.
